// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU control and execute stages.
//   - 4-bit ALU function codes driven by the control stage
//   - execute-stage FSM state type
//   - shifter operation selects (low two bits of the shift function codes)
package alu_pkg;

  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [FUNC_W-1:0] FN_SLL = 4'b0000;
  localparam logic [FUNC_W-1:0] FN_SRL = 4'b0001;
  localparam logic [FUNC_W-1:0] FN_SRA = 4'b0010;
  localparam logic [FUNC_W-1:0] FN_ADD = 4'b1000;
  localparam logic [FUNC_W-1:0] FN_SUB = 4'b1001;
  localparam logic [FUNC_W-1:0] FN_AND = 4'b1100;
  localparam logic [FUNC_W-1:0] FN_OR  = 4'b1101;
  localparam logic [FUNC_W-1:0] FN_NOR = 4'b1110;
  localparam logic [FUNC_W-1:0] FN_XOR = 4'b1111;

  // Shift selects match func[1:0] of the shift codes
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// alu_shifter: shift datapath for alu_exec.
// Build option: ALU_BARREL_SHIFT_EN
//   defined   -> purely combinational barrel shifter of i_data by i_shamt
//   undefined -> iterative shifter, one bit per cycle
// Ports (iterative build):
//   i_clk, i_rst_n  clock / async active-low reset
//   i_load          capture i_data, i_shamt, i_op
//   i_step          advance the shift register by one bit
//   o_last_c        the pending step is the final one
// Ports (both builds):
//   i_op            shift select (SH_SLL/SH_SRL/SH_SRA)
//   i_data, i_shamt operand and shift amount
//   o_value_c       barrel: shifted result; iterative: value after next step
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
`ifndef ALU_BARREL_SHIFT_EN
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  output logic               o_last_c,
`endif
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [4:0]         i_shamt,
  output logic [WIDTH-1:0]   o_value_c
);

`ifdef ALU_BARREL_SHIFT_EN

  // Single-cycle shift; SRA replicates the sign bit of i_data
  always_comb begin
    o_value_c = i_data;
    case (i_op)
      SH_SRL:  o_value_c = i_data >> i_shamt;
      SH_SRA:  o_value_c = WIDTH'($signed(i_data) >>> i_shamt);
      default: o_value_c = i_data << i_shamt;
    endcase
  end

`else

  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step_c;

  // One-bit shift of the held value; SRA refills from the current MSB,
  // which stays equal to the original sign bit throughout
  always_comb begin
    step_c = {shreg_q[WIDTH-2:0], 1'b0};
    case (op_q)
      SH_SRL:  step_c = {1'b0, shreg_q[WIDTH-1:1]};
      SH_SRA:  step_c = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: step_c = {shreg_q[WIDTH-2:0], 1'b0};
    endcase
  end

  // Operand capture and per-cycle shift with remaining-step counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
    end else if (i_load) begin
      shreg_q <= i_data;
      cnt_q   <= i_shamt;
      op_q    <= i_op;
    end else if (i_step) begin
      shreg_q <= step_c;
      cnt_q   <= cnt_q - 5'd1;
    end
  end

  assign o_value_c = step_c;
  assign o_last_c  = (cnt_q == 5'd1);

`endif

endmodule : alu_shifter

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with valid/ready request handshake.
// Logic/arithmetic ops complete in one cycle; shifts use alu_shifter.
// Build option: ALU_BARREL_SHIFT_EN
//   defined   -> all shifts single-cycle, SHIFT state never entered
//   undefined -> iterative shift, o_valid N+1 cycles after acceptance
// Ports:
//   i_clk, i_rst_n   clock / async active-low reset
//   i_valid/o_ready  request handshake (accept when both high)
//   i_alu_func       4-bit function code (see alu_pkg)
//   i_a, i_b         operands; shifts operate on i_b
//   i_shamt          shift amount
//   o_valid          one-cycle result strobe
//   o_result, o_zero, o_overflow, o_illegal  result and flags, held
//                    between strobes
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_alu_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [4:0]       i_shamt,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_illegal
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             illegal_c;
  logic [WIDTH-1:0] sh_value_c;

  assign sum_c  = i_a + i_b;
  assign diff_c = i_a - i_b;

`ifndef ALU_BARREL_SHIFT_EN
  logic shift_c;
  logic iter_c;
  logic sh_last_c;

  // Only non-zero shift amounts take the multi-cycle path
  assign iter_c = shift_c && (i_shamt != 5'd0);

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (i_valid && o_ready && iter_c),
    .i_step    (state_q == ST_SHIFT),
    .o_last_c  (sh_last_c),
    .i_op      (i_alu_func[1:0]),
    .i_data    (i_b),
    .i_shamt   (i_shamt),
    .o_value_c (sh_value_c)
  );
`else
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_op      (i_alu_func[1:0]),
    .i_data    (i_b),
    .i_shamt   (i_shamt),
    .o_value_c (sh_value_c)
  );
`endif

  // Function decode; unlisted codes (X/Z included) fall to illegal
  always_comb begin
    res_c     = '0;
    ovf_c     = 1'b0;
    illegal_c = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    shift_c   = 1'b0;
`endif
    case (i_alu_func)
      FN_ADD: begin
        res_c = sum_c;
        ovf_c = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum_c[WIDTH-1] != i_a[WIDTH-1]);
      end
      FN_SUB: begin
        res_c = diff_c;
        ovf_c = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff_c[WIDTH-1] != i_a[WIDTH-1]);
      end
      FN_AND: res_c = i_a & i_b;
      FN_OR:  res_c = i_a | i_b;
      FN_NOR: res_c = ~(i_a | i_b);
      FN_XOR: res_c = i_a ^ i_b;
      FN_SLL, FN_SRL, FN_SRA: begin
`ifdef ALU_BARREL_SHIFT_EN
        res_c = sh_value_c;
`else
        // Zero shift amount completes immediately with the unshifted operand
        shift_c = 1'b1;
        res_c   = i_b;
`endif
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Control FSM with registered handshake, strobe and result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_zero     <= 1'b1;
      o_overflow <= 1'b0;
      o_illegal  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
            if (iter_c) begin
              state_q <= ST_SHIFT;
              o_ready <= 1'b0;
            end else
`endif
            begin
              state_q    <= ST_DONE;
              o_valid    <= 1'b1;
              o_result   <= res_c;
              o_zero     <= (res_c == '0);
              o_overflow <= ovf_c;
              o_illegal  <= illegal_c;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
          // Final step lands directly in the result register
          if (sh_last_c) begin
            state_q    <= ST_DONE;
            o_ready    <= 1'b1;
            o_valid    <= 1'b1;
            o_result   <= sh_value_c;
            o_zero     <= (sh_value_c == '0);
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
          end
`else
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. Driver pushes expected
// responses (directed constants or reference model) with their expected
// arrival cycle; a negedge monitor pops and compares on each o_valid.
module tb_alu_exec;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_alu_func = 4'h0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [4:0]  i_shamt = '0;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_overflow;
  logic        o_illegal;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   cyc = 0;
  int   tot = 0;
  int   bad = 0;

  alu_exec #(.WIDTH(32)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_alu_func (i_alu_func),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_shamt    (i_shamt),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_illegal  (o_illegal)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t make_exp(input logic [31:0] r, input logic z, input logic ov, input logic il);
    exp_t e;
    e.res = r; e.zero = z; e.ovf = ov; e.ill = il; e.cyc = 0;
    return e;
  endfunction

  // Reference behaviour from plain arithmetic on signed 64-bit values
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t   e;
    longint s;
    e = make_exp(32'h0, 1'b0, 1'b0, 1'b0);
    case (f)
      4'b1000: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1001: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1100: e.res = a & b;
      4'b1101: e.res = a | b;
      4'b1110: e.res = ~(a | b);
      4'b1111: e.res = a ^ b;
      4'b0000: e.res = b << sh;
      4'b0001: e.res = b >> sh;
      4'b0010: e.res = 32'($signed(b) >>> sh);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] f, input logic [4:0] sh);
    int l;
    l = 1;
`ifndef ALU_BARREL_SHIFT_EN
    if ((f == 4'b0000 || f == 4'b0001 || f == 4'b0010) && sh != 5'd0) l = int'(sh) + 1;
`endif
    return l;
  endfunction

  // Called just after a negedge; returns one negedge after acceptance.
  // While the DUT is busy, junk requests are presented to prove they are ignored.
  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input exp_t e_in, input bit use_model);
    int   waitc;
    exp_t e;
    waitc   = 0;
    i_valid = 1'b1;
    while (!o_ready && waitc < 100) begin
      i_alu_func = 4'($urandom);
      i_a        = $urandom;
      i_b        = $urandom;
      i_shamt    = 5'($urandom);
      @(negedge i_clk);
      waitc++;
    end
    if (!o_ready) begin
      check("accept_timeout", 64'(o_ready), 64'd1);
      i_valid = 1'b0;
      return;
    end
    i_alu_func = f;
    i_a        = a;
    i_b        = b;
    i_shamt    = sh;
    e          = use_model ? model(f, a, b, sh) : e_in;
    e.cyc      = cyc + latency(f, sh);
    exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  // Monitor: scoreboard compare on o_valid, hold check otherwise
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(o_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("latency",  64'(cyc),        64'(e.cyc));
          check("result",   64'(o_result),   64'(e.res));
          check("zero",     64'(o_zero),     64'(e.zero));
          check("overflow", 64'(o_overflow), 64'(e.ovf));
          check("illegal",  64'(o_illegal),  64'(e.ill));
          last_e = e;
        end
      end else begin
        check("hold", 64'({o_result, o_zero, o_overflow, o_illegal}),
              64'({last_e.res, last_e.zero, last_e.ovf, last_e.ill}));
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          check("missing_valid", 64'(o_valid), 64'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [14];
    exp_t       dummy;
    logic [3:0] f;
    logic [4:0] sh;
    codes = '{4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111,
              4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0111, 4'b1010, 4'b1011};
    dummy  = make_exp(32'h0, 1'b1, 1'b0, 1'b0);
    last_e = make_exp(32'h0, 1'b1, 1'b0, 1'b0);

    // Reset values
    repeat (3) @(negedge i_clk);
    check("rst_ready",    64'(o_ready),    64'd1);
    check("rst_valid",    64'(o_valid),    64'd0);
    check("rst_result",   64'(o_result),   64'd0);
    check("rst_zero",     64'(o_zero),     64'd1);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_illegal",  64'(o_illegal),  64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // ADD overflow at the positive limit
    issue(4'b1000, 32'h7FFF_FFFF, 32'h1, 5'd0, make_exp(32'h8000_0000, 1'b0, 1'b1, 1'b0), 1'b0);
    idle(2);
    // SUB to zero
    issue(4'b1001, 32'd5, 32'd5, 5'd0, make_exp(32'h0, 1'b1, 1'b0, 1'b0), 1'b0);
    idle(2);
    // SRA sign fill, ready low while shifting
    issue(4'b0010, 32'h0, 32'h8000_0000, 5'd4, make_exp(32'hF800_0000, 1'b0, 1'b0, 1'b0), 1'b0);
    i_valid = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    for (int i = 0; i < 4; i++) begin
      check("ready_in_shift", 64'(o_ready), 64'd0);
      @(negedge i_clk);
    end
`else
    check("ready_barrel", 64'(o_ready), 64'd1);
`endif
    idle(3);
    // Back-to-back AND then OR
    issue(4'b1100, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, make_exp(32'h0000_F000, 1'b0, 1'b0, 1'b0), 1'b0);
    issue(4'b1101, 32'h1, 32'h2, 5'd0, make_exp(32'h3, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(2);
    // Unsupported code
    issue(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, make_exp(32'h0, 1'b1, 1'b0, 1'b1), 1'b0);
    idle(2);
    // SLL with zero shift amount returns i_b in one cycle
    issue(4'b0000, 32'h0, 32'hDEAD_BEEF, 5'd0, make_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(2);

    // Reset during a long SLL: no result for the aborted request
    issue(4'b0000, 32'h0, 32'h0000_0001, 5'd31, make_exp(32'h8000_0000, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(10);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    exp_q.delete();
    last_e = make_exp(32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("abort_ready",  64'(o_ready),  64'd1);
    check("abort_valid",  64'(o_valid),  64'd0);
    check("abort_result", 64'(o_result), 64'd0);
    check("abort_zero",   64'(o_zero),   64'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(40);

    // Randomised traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      f  = codes[$urandom_range(0, 13)];
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      issue(f, $urandom, $urandom, sh, dummy, 1'b1);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // Drain
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge i_clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule : tb_alu_exec
